// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer logic: Gray/binary conversion,
// population count and the synchroniser FSM state type.
package fifo_pkg;

  localparam int STAGES_MAX = 4;
  localparam int PTR_W_MAX  = 32;
  localparam int PC_W       = $clog2(PTR_W_MAX) + 1;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } sync_state_e;

  // Callers zero-extend a PW-bit pointer to PTR_W_MAX bits. Zero upper bits
  // leave the low PW bits of every result identical to a native PW-bit version.
  function automatic logic [PTR_W_MAX-1:0] bin2gray(input logic [PTR_W_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_W_MAX-1:0] gray2bin(input logic [PTR_W_MAX-1:0] g);
    logic [PTR_W_MAX-1:0] b;
    b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
    for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [PC_W-1:0] popcount(input logic [PTR_W_MAX-1:0] v);
    logic [PC_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < PTR_W_MAX; i++) begin
      cnt = cnt + {{(PC_W-1){1'b0}}, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain N-flop synchroniser with synchronous reset. It is shared by the
// read-side and write-side pointer synchronisers.
module sync_chain #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  (* ASYNC_REG = "TRUE", dont_touch = "true" *)
  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/sync_ptr_gen.sv
// Brings an asynchronous Gray pointer into the rclk domain and derives the
// binary pointer, its per-cycle advance, a valid qualifier and a step check.
module sync_ptr_gen
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE = 4,
  parameter int STAGES   = 2,
  parameter int CHECK_EN = 1,
  parameter int ECNT_W   = 8
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [ADDRSIZE:0]   wptr_gray,
  input  logic                err_clr,
  output logic [ADDRSIZE:0]   rq_gray,
  output logic [ADDRSIZE:0]   rq_bin,
  output logic [ADDRSIZE:0]   rq_delta,
  output logic                rq_valid,
  output logic                err_step,
  output logic [ECNT_W-1:0]   err_cnt,
  output logic                dbg_state
);

  localparam int PW    = ADDRSIZE + 1;
  localparam int CNT_W = $clog2(STAGES_MAX + 2);

  generate
    if (STAGES < 2 || STAGES > STAGES_MAX) begin : g_bad_stages
      $error("sync_ptr_gen: STAGES must lie in 2..%0d", STAGES_MAX);
    end
    if (PW >= PTR_W_MAX) begin : g_bad_width
      $error("sync_ptr_gen: ADDRSIZE too large for fifo_pkg helpers");
    end
  endgenerate

  sync_state_e          state;
  sync_state_e          state_nxt;
  logic [CNT_W-1:0]     init_cnt;
  logic [CNT_W-1:0]     init_cnt_nxt;
  logic [PW-1:0]        gray_prev;
  logic [PW-1:0]        bin_next;
  logic [PTR_W_MAX-PW-1:0] unused_bin_hi;
  logic [PC_W-1:0]      flip_cnt;
  logic                 step_viol;

  sync_chain #(
    .WIDTH  (PW),
    .STAGES (STAGES)
  ) u_chain (
    .clk (rclk),
    .rst (rrst),
    .d   (wptr_gray),
    .q   (rq_gray)
  );

  // INIT holds until the chain and the decode register have been refilled
  // with post-reset data.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    case (state)
      INIT: begin
        if (init_cnt == CNT_W'(STAGES)) begin
          state_nxt = RUN;
        end else begin
          init_cnt_nxt = init_cnt + 1'b1;
        end
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  assign rq_valid  = (state == RUN);
  assign dbg_state = state;

  assign {unused_bin_hi, bin_next} = gray2bin({{(PTR_W_MAX-PW){1'b0}}, rq_gray});
  assign flip_cnt  = popcount({{(PTR_W_MAX-PW){1'b0}}, rq_gray ^ gray_prev});
  assign step_viol = (state == RUN) && (flip_cnt > PC_W'(1));

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rq_bin    <= '0;
      rq_delta  <= '0;
      gray_prev <= '0;
    end else begin
      rq_bin    <= bin_next;
      rq_delta  <= (state == INIT) ? '0 : bin_next - rq_bin;
      gray_prev <= rq_gray;
    end
  end

  generate
    if (CHECK_EN != 0) begin : g_check
      // A violation in the same cycle as err_clr restarts the count at one.
      always_ff @(posedge rclk) begin
        if (rrst) begin
          err_step <= 1'b0;
          err_cnt  <= '0;
        end else if (step_viol) begin
          err_step <= 1'b1;
          if (err_clr) begin
            err_cnt <= ECNT_W'(1);
          end else if (err_cnt != '1) begin
            err_cnt <= err_cnt + ECNT_W'(1);
          end
        end else if (err_clr) begin
          err_step <= 1'b0;
          err_cnt  <= '0;
        end
      end
    end else begin : g_nocheck
      assign err_step = 1'b0;
      assign err_cnt  = '0;
    end
  endgenerate

endmodule

// File: tb/tb_sync_ptr_gen.sv
// Bench for sync_ptr_gen: three instances (STAGES=2, STAGES=4, CHECK_EN=0)
// driven one at a time against a cycle model fed from an expected queue.
module tb_sync_ptr_gen;

  localparam int PW = 5;
  localparam int NI = 3;

  logic          rclk = 1'b0;
  logic          rrst = 1'b1;
  logic [PW-1:0] wp     [NI];
  logic          clr    [NI];
  logic [PW-1:0] o_gray [NI];
  logic [PW-1:0] o_bin  [NI];
  logic [PW-1:0] o_delta[NI];
  logic          o_valid[NI];
  logic          o_err  [NI];
  logic          o_state[NI];
  logic [7:0]    o_cnt  [NI];

  always #5 rclk = ~rclk;

  sync_ptr_gen #(.ADDRSIZE(4), .STAGES(2), .CHECK_EN(1), .ECNT_W(8)) u_s2 (
    .rclk(rclk), .rrst(rrst), .wptr_gray(wp[0]), .err_clr(clr[0]),
    .rq_gray(o_gray[0]), .rq_bin(o_bin[0]), .rq_delta(o_delta[0]),
    .rq_valid(o_valid[0]), .err_step(o_err[0]), .err_cnt(o_cnt[0]),
    .dbg_state(o_state[0]));

  sync_ptr_gen #(.ADDRSIZE(4), .STAGES(4), .CHECK_EN(1), .ECNT_W(8)) u_s4 (
    .rclk(rclk), .rrst(rrst), .wptr_gray(wp[1]), .err_clr(clr[1]),
    .rq_gray(o_gray[1]), .rq_bin(o_bin[1]), .rq_delta(o_delta[1]),
    .rq_valid(o_valid[1]), .err_step(o_err[1]), .err_cnt(o_cnt[1]),
    .dbg_state(o_state[1]));

  sync_ptr_gen #(.ADDRSIZE(4), .STAGES(2), .CHECK_EN(0), .ECNT_W(8)) u_nochk (
    .rclk(rclk), .rrst(rrst), .wptr_gray(wp[2]), .err_clr(clr[2]),
    .rq_gray(o_gray[2]), .rq_bin(o_bin[2]), .rq_delta(o_delta[2]),
    .rq_valid(o_valid[2]), .err_step(o_err[2]), .err_cnt(o_cnt[2]),
    .dbg_state(o_state[2]));

  // model / scoreboard state
  int            sel;
  int            stg;
  bit            chk;
  logic [PW-1:0] exp_q[$];
  int            n_cyc;
  logic [PW-1:0] last_bin;
  logic [PW-1:0] last_gray;
  logic          m_step;
  int            m_cnt;
  int            n_vec;
  int            n_bad;

  function automatic logic [PW-1:0] b2g(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = g;
    for (int i = 1; i < PW; i++) b = b ^ (g >> i);
    return b;
  endfunction

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (dut %0d, cycle %0d, t=%0t)",
               tag, got, exp, sel, n_cyc, $time);
    end
  endtask

  task automatic set_dut(input int s);
    sel = s;
    stg = (s == 1) ? 4 : 2;
    chk = (s != 2);
  endtask

  // Called at a falling edge; leaves rrst low at a falling edge.
  task automatic do_reset(input int ncyc);
    rrst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      wp[i]  = '0;
      clr[i] = 1'b0;
    end
    repeat (ncyc) @(posedge rclk);
    @(negedge rclk);
    chk_val("rst_gray",  32'(o_gray[sel]),  32'd0);
    chk_val("rst_bin",   32'(o_bin[sel]),   32'd0);
    chk_val("rst_delta", 32'(o_delta[sel]), 32'd0);
    chk_val("rst_valid", 32'(o_valid[sel]), 32'd0);
    chk_val("rst_err",   32'(o_err[sel]),   32'd0);
    chk_val("rst_cnt",   32'(o_cnt[sel]),   32'd0);
    rrst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < stg; i++) exp_q.push_back('0);
    n_cyc     = 0;
    last_bin  = '0;
    last_gray = '0;
    m_step    = 1'b0;
    m_cnt     = 0;
  endtask

  task automatic step(input logic [PW-1:0] g, input logic c);
    logic [PW-1:0] gp;
    logic [PW-1:0] b;
    logic [PW-1:0] d;
    bit            viol;
    wp[sel]  = g;
    clr[sel] = c;
    exp_q.push_back(g);
    @(posedge rclk);
    @(negedge rclk);
    n_cyc++;
    gp   = exp_q.pop_front();
    b    = g2b(gp);
    d    = (n_cyc <= stg + 1) ? '0 : PW'(b - last_bin);
    viol = chk && (n_cyc > stg + 1) && ($countones(gp ^ last_gray) > 1);
    if (viol) begin
      m_step = 1'b1;
      m_cnt  = c ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
    end else if (c) begin
      m_step = 1'b0;
      m_cnt  = 0;
    end
    chk_val("gray",  32'(o_gray[sel]),  32'(exp_q[0]));
    chk_val("bin",   32'(o_bin[sel]),   32'(b));
    chk_val("delta", 32'(o_delta[sel]), 32'(d));
    chk_val("valid", 32'(o_valid[sel]), (n_cyc >= stg + 1) ? 32'd1 : 32'd0);
    chk_val("state", 32'(o_state[sel]), (n_cyc >= stg + 1) ? 32'd1 : 32'd0);
    chk_val("err",   32'(o_err[sel]),   32'(m_step));
    chk_val("cnt",   32'(o_cnt[sel]),   32'(m_cnt));
    last_bin  = b;
    last_gray = gp;
  endtask

  task automatic step_bin(input logic [PW-1:0] b, input logic c);
    step(b2g(b), c);
  endtask

  // Drives a new value once, then holds it until rq_bin follows (bounded).
  task automatic measure_latency(input logic [PW-1:0] b);
    int k;
    step_bin(b, 1'b0);
    k = 1;
    while (o_bin[sel] != b && k < 12) begin
      step_bin(b, 1'b0);
      k++;
    end
    chk_val("latency", 32'(k), 32'(stg + 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [PW-1:0] cur;
    n_vec = 0;
    n_bad = 0;
    for (int i = 0; i < NI; i++) begin
      wp[i]  = '0;
      clr[i] = 1'b0;
    end

    // STAGES=2: reset release, latency, wrap
    set_dut(0);
    do_reset(3);
    repeat (5) step(5'b0, 1'b0);
    measure_latency(5'd1);
    repeat (2) step_bin(5'd1, 1'b0);
    for (int b = 2; b < 32; b++) step_bin(PW'(b), 1'b0);
    step_bin(5'd0, 1'b0);
    step_bin(5'd1, 1'b0);
    repeat (4) step_bin(5'd1, 1'b0);
    chk_val("wrap_err", 32'(o_err[sel]), 32'd0);

    // Gray jump 00000 -> 00011, then saturate the counter
    step(5'b00000, 1'b0);
    repeat (3) step(5'b00000, 1'b0);
    step(5'b00011, 1'b0);
    repeat (3) step(5'b00011, 1'b0);
    chk_val("jump_cnt", 32'(o_cnt[sel]), 32'd1);
    for (int i = 0; i < 300; i++) step((i % 2 == 0) ? 5'b00000 : 5'b00011, 1'b0);
    step(5'b00011, 1'b0);
    repeat (3) step(5'b00011, 1'b0);
    chk_val("sat_cnt", 32'(o_cnt[sel]), 32'd255);

    // err_clr colliding with a fresh violation, then err_clr alone
    step(5'b00000, 1'b0);
    repeat (stg - 1) step(5'b00000, 1'b0);
    step(5'b00000, 1'b1);
    chk_val("collide_err", 32'(o_err[sel]), 32'd1);
    chk_val("collide_cnt", 32'(o_cnt[sel]), 32'd1);
    repeat (3) step(5'b00000, 1'b0);
    step(5'b00000, 1'b1);
    chk_val("clr_err", 32'(o_err[sel]), 32'd0);
    chk_val("clr_cnt", 32'(o_cnt[sel]), 32'd0);

    // random legal advances with occasional illegal jumps and clears
    cur = '0;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 15) == 0) cur = g2b(PW'($urandom_range(0, 31)));
      else cur = cur + PW'($urandom_range(0, 1));
      step_bin(cur, ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
    end

    // mid-operation reset with rq_bin = 9
    while (cur != 5'd9) begin
      cur = cur + 1'b1;
      step_bin(cur, 1'b0);
    end
    repeat (4) step_bin(5'd9, 1'b0);
    chk_val("pre_rst_bin", 32'(o_bin[sel]), 32'd9);
    do_reset(1);
    repeat (6) step(5'b0, 1'b0);

    // STAGES=4
    set_dut(1);
    do_reset(2);
    repeat (7) step(5'b0, 1'b0);
    measure_latency(5'd1);
    for (int b = 2; b <= 9; b++) step_bin(PW'(b), 1'b0);
    repeat (6) step_bin(5'd9, 1'b0);
    for (int i = 0; i < 20; i++) step((i % 2 == 0) ? 5'b01101 : 5'b01110, 1'b0);
    repeat (6) step(5'b01110, 1'b0);
    chk_val("s4_err", 32'(o_err[sel]), 32'd1);

    // CHECK_EN=0
    set_dut(2);
    do_reset(2);
    repeat (5) step(5'b0, 1'b0);
    for (int i = 0; i < 40; i++)
      step((i % 2 == 0) ? 5'b00011 : 5'b00000, ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
    repeat (4) step(5'b00000, 1'b0);
    chk_val("nochk_err", 32'(o_err[sel]), 32'd0);
    chk_val("nochk_cnt", 32'(o_cnt[sel]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
